// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder FSM states, add/sub op-codes and a
// constant-evaluable ceil(log2) for sizing counters.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder built from fac cells; also exposes the carry into the
// top bit so the caller can derive signed overflow on the last chunk.
module addsub_chunk #(
  parameter int CHUNK = 6
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fac u_fac (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/fac.sv
// Single-bit full-adder cell.
module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through one registered
// carry, start/busy/done handshake, result and flags held between completions.
module addsub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NSTEPS = WIDTH / CHUNK;
  localparam int SW     = (NSTEPS > 1) ? clog2(NSTEPS) : 1;

  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("addsub_serial: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q;
  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q;
  logic [CHUNK-1:0] a_c, b_c, sum_c;
  logic             co_c, cmsb_c, last;

  always_comb begin
    a_c   = a_q[int'(step_q)*CHUNK +: CHUNK];
    b_c   = b_q[int'(step_q)*CHUNK +: CHUNK];
    acc_d = acc_q;
    acc_d[int'(step_q)*CHUNK +: CHUNK] = sum_c;
    last  = (step_q == SW'(NSTEPS - 1));
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(a_c), .b(b_c), .cin(carry_q),
    .sum(sum_c), .cout(co_c), .c_msb_in(cmsb_c)
  );

  // The final chunk's sum goes straight into res so done and res align.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            a_q     <= op1;
            b_q     <= op2 ^ {WIDTH{s == OP_SUB}};
            carry_q <= (s == OP_SUB);
            step_q  <= '0;
            busy    <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          carry_q <= co_c;
          if (last) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            res     <= acc_d;
            cout    <= co_c;
            ovf     <= cmsb_c ^ co_c;
            zero    <= (acc_d == '0);
            neg     <= acc_d[WIDTH-1];
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: the same stimulus drives four CHUNK configurations; each
// completion is checked against an independent (op1 +/- op2) model and latency.
module tb_addsub_serial;
  localparam int W    = 18;
  localparam int NCFG = 4;
  localparam int CHS [NCFG] = '{6, 1, 9, 18};

  typedef struct {
    logic [W+3:0] v;
    int           e0;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [NCFG-1:0] busy_v, done_v, cout_v, ovf_v, zero_v, neg_v;
  logic [NCFG-1:0][W-1:0] res_v;

  int   cyc = 0, checks = 0, errors = 0;
  exp_t sbq [NCFG][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    addsub_serial #(.WIDTH(W), .CHUNK(CHS[g])) u_dut (
      .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .s(s),
      .busy(busy_v[g]), .done(done_v[g]), .res(res_v[g]), .cout(cout_v[g]),
      .ovf(ovf_v[g]), .zero(zero_v[g]), .neg(neg_v[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (done_v[g]) begin
        if (sbq[g].size() == 0) begin
          chk($sformatf("spurious_done_c%0d", CHS[g]), 64'd1, 64'd0);
        end else begin
          e = sbq[g].pop_front();
          chk($sformatf("result_c%0d", CHS[g]),
              64'({res_v[g], cout_v[g], ovf_v[g], zero_v[g], neg_v[g]}), 64'(e.v));
          chk($sformatf("latency_c%0d", CHS[g]), 64'(cyc - e.e0), 64'(W / CHS[g]));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {res, cout, ovf, zero, neg} from a plain-arithmetic reference
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (sub) full = {1'b0, a} - {1'b0, b} + (1'b1 << W);
    else     full = {1'b0, a} + {1'b0, b};
    r = full[W-1:0];
    if (sub) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else     v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {r, full[W], v, (r == '0), r[W-1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    start = 1'b1; op1 = a; op2 = b; s = sub;
    e.v  = model(a, b, sub);
    e.e0 = cyc + 1;
    for (int i = 0; i < NCFG; i++)
      if (!busy_v[i]) sbq[i].push_back(e);
    step();
    start = 1'b0;
    op1 = $urandom; op2 = $urandom; s = $urandom_range(0, 1);
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NCFG; i++) n += sbq[i].size();
    return n;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((pending() != 0 || busy_v != '0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({"timeout_", tag}, 64'(pending()), 64'd0);
  endtask

  logic [W-1:0] da [7] = '{18'd5, 18'h1FFFF, 18'h3FFFF, 18'd5, 18'd3, 18'h20000, 18'd0};
  logic [W-1:0] db [7] = '{18'd3, 18'h00001, 18'h00001, 18'd5, 18'd5, 18'd1, 18'd0};
  logic         ds [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // reset held with start asserted: reset must win
    start = 1'b1; op1 = 18'd7; op2 = 18'd9;
    step(); step();
    start = 1'b0;
    step();
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    chk("rst_res",  64'(res_v[0]), 64'd0);
    chk("rst_flags", 64'({cout_v, ovf_v, zero_v, neg_v}), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i], ds[i]);
      chk("busy_run", 64'(busy_v[0]), 64'd1);
      wait_idle("directed");
    end

    // start during RUN is ignored by the 6-bit chunk config; start in DONE is taken
    issue(18'h12345, 18'h01111, 1'b0);
    issue(18'h3AAAA, 18'h05555, 1'b1);
    begin
      int n;
      n = 0;
      while (!done_v[0] && n < 20) begin step(); n++; end
      chk("b2b_done_seen", 64'(done_v[0]), 64'd1);
    end
    issue(18'h00ABC, 18'h00DEF, 1'b1);
    wait_idle("b2b");

    // reset on the second RUN cycle aborts without a done pulse
    issue(18'h1F0F0, 18'h0F0F0, 1'b0);
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < NCFG; i++) sbq[i].delete();
    chk("abort_busy", 64'(busy_v), 64'd0);
    chk("abort_done", 64'(done_v), 64'd0);
    chk("abort_res",  64'(res_v), 64'd0);
    chk("abort_flags", 64'({cout_v, ovf_v, zero_v, neg_v}), 64'd0);
    rst = 1'b0;
    issue(18'd100, 18'd23, 1'b1);
    wait_idle("after_abort");

    // random regression with irregular start timing
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      else step();
    end
    wait_idle("random");
    chk("drain", 64'(pending()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
